// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file responder.
// Used by apb_slv_addr_decode and apb_slave_regfile.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int   REG_STRIDE = 4;
    localparam int   IDX_WIDTH  = 6;
    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_SLVERR = 1'b1;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic                 in_range;
        logic                 aligned;
        logic                 ro_hit;
    } addr_chk_t;

    // Uses the whole select bus so every bit is accounted for, but only one bit can match.
    function automatic logic psel_hit(input logic [15:0] psel, input int unsigned bit_idx);
        return |(psel & (16'd1 << bit_idx));
    endfunction

endpackage

// File: rtl/apb_slv_addr_decode.sv
// Combinational address check: byte address -> register index plus range,
// alignment and read-only-register flags relative to the bank base.
module apb_slv_addr_decode
    import apb_slv_pkg::*;
#(
    parameter int          PADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          NUM_REGS    = 8
) (
    input  logic [PADDR_WIDTH-1:0] paddr,
    output addr_chk_t              chk
);

    localparam logic [PADDR_WIDTH-1:0] BASE = PADDR_WIDTH'(BASE_ADDR);
    localparam logic [PADDR_WIDTH-1:0] SPAN = PADDR_WIDTH'(NUM_REGS * REG_STRIDE);

    logic [PADDR_WIDTH-1:0] off_s;

    // Offset wraps modulo 2^PADDR_WIDTH, so addresses below the base land far out of range.
    always_comb begin
        off_s        = paddr - BASE;
        chk.idx      = off_s[7:2];
        chk.in_range = (off_s < SPAN);
        chk.aligned  = (paddr[1:0] == 2'b00);
        chk.ro_hit   = (off_s < SPAN) && (off_s[7:2] == 6'd0);
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer serving a bank of 32-bit registers (reg0 = hw_status, read-only).
// Optional wait-state insertion is built only when APB_SLV_WAIT_EN is defined.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int          PADDR_WIDTH = 32,
    parameter int          PDATA_WIDTH = 32,
    parameter int          PSEL_IDX    = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                   pclock,
    input  logic                   preset,
    input  logic [PADDR_WIDTH-1:0] paddr,
    input  logic                   prwd,
    input  logic [PDATA_WIDTH-1:0] pwdata,
    input  logic                   penable,
    input  logic [15:0]            psel,
    input  logic [PDATA_WIDTH-1:0] hw_status,
    output logic [PDATA_WIDTH-1:0] prdata,
    output logic                   pslverr,
    output logic                   pready,
    output logic [PDATA_WIDTH-1:0] ctrl_out
);

    if ((NUM_REGS < 2) || (NUM_REGS > 64) || (PSEL_IDX < 0) || (PSEL_IDX > 15) ||
        (WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_param_err
        $error("apb_slave_regfile: parameter out of range");
    end

    state_t                 state_r;
    state_t                 state_s;
    logic                   sel_s;
    logic                   setup_s;
    addr_chk_t              chk_s;
    addr_chk_t              chk_r;
    logic                   write_r;
    logic [PDATA_WIDTH-1:0] wdata_r;
    addr_chk_t              req_chk_s;
    logic                   req_wr_s;
    logic                   req_err_s;
    logic [PDATA_WIDTH-1:0] rd_val_s;
    logic                   commit_s;
    logic                   pready_s;
    logic                   pslverr_s;
    logic [PDATA_WIDTH-1:0] prdata_s;
    logic                   pready_r;
    logic                   pslverr_r;
    logic [PDATA_WIDTH-1:0] prdata_r;
    logic [PDATA_WIDTH-1:0] regs_r [1:NUM_REGS-1];

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
`endif

    apb_slv_addr_decode #(
        .PADDR_WIDTH (PADDR_WIDTH),
        .BASE_ADDR   (BASE_ADDR),
        .NUM_REGS    (NUM_REGS)
    ) u_addr_decode (
        .paddr (paddr),
        .chk   (chk_s)
    );

    assign sel_s   = psel_hit(psel, PSEL_IDX);
    assign setup_s = (state_r == IDLE) && sel_s && !penable;

    // With zero wait the response is built on the setup edge itself, before the latch holds it.
    assign req_chk_s = (state_r == IDLE) ? chk_s : chk_r;
    assign req_wr_s  = (state_r == IDLE) ? prwd  : write_r;
    assign req_err_s = !req_chk_s.aligned || !req_chk_s.in_range || (req_wr_s && req_chk_s.ro_hit);

    assign commit_s = (state_r == RESP) && sel_s && penable && write_r && (pslverr_r == ERR_NONE);

    // Next-state logic: setup in IDLE, optional wait countdown, single-cycle RESP.
    always_comb begin
        state_s = state_r;
`ifdef APB_SLV_WAIT_EN
        cnt_s   = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (setup_s) begin
`ifdef APB_SLV_WAIT_EN
                    if (WAIT_CYCLES == 0) begin
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = WAIT_LOAD;
                    end
`else
                    state_s = RESP;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
`ifdef APB_SLV_WAIT_EN
                if (!sel_s) begin
                    state_s = IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
`else
                state_s = IDLE;
`endif
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Read mux: reg0 reflects live hw_status, the rest come from the bank.
    always_comb begin
        rd_val_s = {PDATA_WIDTH{1'b0}};
        if (req_chk_s.idx == 6'd0) begin
            rd_val_s = hw_status;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                rd_val_s = (req_chk_s.idx == 6'(i)) ? regs_r[i] : rd_val_s;
            end
        end
    end

    // Response values for the coming cycle; everything is zero outside RESP.
    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = ERR_NONE;
        prdata_s  = {PDATA_WIDTH{1'b0}};
        if (state_s == RESP) begin
            pready_s  = 1'b1;
            pslverr_s = req_err_s ? ERR_SLVERR : ERR_NONE;
            prdata_s  = (req_err_s || req_wr_s) ? {PDATA_WIDTH{1'b0}} : rd_val_s;
        end else begin
            pready_s  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

`ifdef APB_SLV_WAIT_EN
    // Wait-state counter.
    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    // Request capture at the setup phase.
    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            chk_r   <= '{idx: 6'd0, in_range: 1'b0, aligned: 1'b0, ro_hit: 1'b0};
            write_r <= 1'b0;
            wdata_r <= {PDATA_WIDTH{1'b0}};
        end else if (setup_s) begin
            chk_r   <= chk_s;
            write_r <= prwd;
            wdata_r <= pwdata;
        end
    end

    // Registered response outputs.
    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            pready_r  <= 1'b0;
            pslverr_r <= ERR_NONE;
            prdata_r  <= {PDATA_WIDTH{1'b0}};
        end else begin
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            prdata_r  <= prdata_s;
        end
    end

    // Register bank; a write lands on the edge that closes an error-free RESP.
    always_ff @(posedge pclock or negedge preset) begin
        if (!preset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_r[i] <= {PDATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit_s && (chk_r.idx == 6'(i))) begin
                    regs_r[i] <= wdata_r;
                end
            end
        end
    end

    assign pready   = pready_r;
    assign pslverr  = pslverr_r;
    assign prdata   = prdata_r;
    assign ctrl_out = regs_r[1];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized self-checking bench for apb_slave_regfile with a behavioural register model.
// Expected wait states follow APB_SLV_WAIT_EN.
module tb_apb_slave_regfile;

    localparam int          PSEL = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NREG = 8;
    localparam int          WCYC = 3;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAIT = WCYC;
`else
    localparam int EXP_WAIT = 0;
`endif
    localparam int BOUND = 40;

    logic        pclock = 1'b0;
    logic        preset;
    logic [31:0] paddr;
    logic        prwd;
    logic [31:0] pwdata;
    logic        penable;
    logic [15:0] psel;
    logic [31:0] hw_status;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pready;
    logic [31:0] ctrl_out;

    apb_slave_regfile #(
        .PADDR_WIDTH (32),
        .PDATA_WIDTH (32),
        .PSEL_IDX    (PSEL),
        .BASE_ADDR   (BASE),
        .NUM_REGS    (NREG),
        .WAIT_CYCLES (WCYC)
    ) dut (
        .pclock    (pclock),
        .preset    (preset),
        .paddr     (paddr),
        .prwd      (prwd),
        .pwdata    (pwdata),
        .penable   (penable),
        .psel      (psel),
        .hw_status (hw_status),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .pready    (pready),
        .ctrl_out  (ctrl_out)
    );

    always #5 pclock = ~pclock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mregs [NREG];
    logic [15:0] sel_bit;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input logic [31:0] addr);
        logic [31:0] off;
        logic [1:0]  low;
        off = addr - BASE;
        low = addr[1:0];
        return (low != 2'd0) || (off >= 32'(NREG * 4)) || (wr && (off / 4 == 0));
    endfunction

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic err, output int acc);
        psel    = sel_bit;
        paddr   = addr;
        prwd    = wr;
        pwdata  = data;
        penable = 1'b0;
        @(posedge pclock); #1;
        penable = 1'b1;
        acc = 1;
        while (!pready && acc < BOUND) begin
            @(posedge pclock); #1;
            acc++;
        end
        rd  = prdata;
        err = pslverr;
        @(posedge pclock); #1;
        psel    = 16'h0;
        penable = 1'b0;
    endtask

    task automatic do_and_check(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data);
        logic [31:0] rd;
        logic        err;
        int          acc;
        logic        e_err;
        logic [31:0] e_rd;
        int          idx;
        e_err = model_err(wr, addr);
        idx   = int'((addr - BASE) >> 2);
        if (e_err)        e_rd = 32'h0;
        else if (idx == 0) e_rd = hw_status;
        else               e_rd = mregs[idx];
        apb_xfer(wr, addr, data, rd, err, acc);
        check_eq({tag, ".latency"}, 32'(acc), 32'(EXP_WAIT + 1));
        check_eq({tag, ".pslverr"}, {31'h0, err}, {31'h0, e_err});
        if (!wr || e_err) check_eq({tag, ".prdata"}, rd, e_rd);
        if (wr && !e_err) mregs[idx] = data;
        check_eq({tag, ".ctrl_out"}, ctrl_out, mregs[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          acc;
        int          seen;
        sel_bit   = 16'h1 << PSEL;
        preset    = 1'b0;
        paddr     = 32'h0;
        prwd      = 1'b0;
        pwdata    = 32'h0;
        penable   = 1'b0;
        psel      = 16'h0;
        hw_status = 32'h0;
        for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
        repeat (3) @(posedge pclock);
        #1;
        check_eq("reset.pready", {31'h0, pready}, 32'h0);
        check_eq("reset.pslverr", {31'h0, pslverr}, 32'h0);
        check_eq("reset.prdata", prdata, 32'h0);
        check_eq("reset.ctrl_out", ctrl_out, 32'h0);
        @(negedge pclock);
        preset = 1'b1;
        @(posedge pclock); #1;

        do_and_check("t1.wr", 1'b1, BASE + 32'h4, 32'h5A5A_0001);
        do_and_check("t1.rd", 1'b0, BASE + 32'h4, 32'h0);
        do_and_check("t2.rd_a", 1'b0, BASE + 32'h8, 32'h0);
        do_and_check("t2.rd_b", 1'b0, BASE + 32'h8, 32'h0);
        do_and_check("t3.wr_reg0", 1'b1, BASE, 32'hFFFF_FFFF);
        do_and_check("t3.rd_oor", 1'b0, BASE + 32'h40, 32'h0);
        do_and_check("t3.rd_unal", 1'b0, BASE + 32'h6, 32'h0);
        hw_status = 32'hDEAD_BEEF;
        do_and_check("t4.status", 1'b0, BASE, 32'h0);

        // Abort: drop the select in the first access cycle.
        psel = sel_bit; paddr = BASE + 32'h4; prwd = 1'b1; pwdata = 32'h1234; penable = 1'b0;
        @(posedge pclock); #1;
        psel = 16'h0; penable = 1'b0;
        @(posedge pclock); #1;
        check_eq("t5.abort.pready", {31'h0, pready}, 32'h0);
        check_eq("t5.abort.prdata", prdata, 32'h0);
        @(posedge pclock); #1;
        check_eq("t5.abort.ctrl_out", ctrl_out, mregs[1]);
        do_and_check("t5.abort.rd", 1'b0, BASE + 32'h4, 32'h0);

        // Wrong select: another psel bit for a full write cycle.
        psel = 16'h0001; paddr = BASE + 32'h4; prwd = 1'b1; pwdata = 32'hFFFF_0000; penable = 1'b0;
        seen = 0;
        @(posedge pclock); #1;
        penable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (pready) seen++;
            @(posedge pclock); #1;
        end
        psel = 16'h0; penable = 1'b0;
        check_eq("t6.wrongsel.pready", 32'(seen), 32'h0);
        @(posedge pclock); #1;
        check_eq("t6.wrongsel.ctrl_out", ctrl_out, mregs[1]);

        // Access phase without setup is ignored.
        psel = sel_bit; paddr = BASE + 32'h4; prwd = 1'b1; pwdata = 32'h0BAD_0BAD; penable = 1'b1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge pclock); #1;
            if (pready) seen++;
        end
        psel = 16'h0; penable = 1'b0;
        check_eq("t7.nosetup.pready", 32'(seen), 32'h0);
        @(posedge pclock); #1;
        check_eq("t7.nosetup.ctrl_out", ctrl_out, mregs[1]);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int          r;
            logic [31:0] off;
            hw_status = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       off = 32'(4 * $urandom_range(0, NREG - 1));
            else if (r == 7) off = 32'(4 * $urandom_range(NREG, NREG + 8));
            else if (r == 8) off = 32'(4 * $urandom_range(0, NREG - 1) + $urandom_range(1, 3));
            else             off = 32'hFFFF_FFFC;
            do_and_check("rand", 1'($urandom_range(0, 1)), BASE + off, $urandom);
        end

        // Reset while a read response is on the bus.
        do_and_check("t8.wr1", 1'b1, BASE + 32'h4, 32'hCAFE_F00D);
        do_and_check("t8.wr2", 1'b1, BASE + 32'h8, 32'hA5A5_5A5A);
        psel = sel_bit; paddr = BASE + 32'h8; prwd = 1'b0; penable = 1'b0;
        @(posedge pclock); #1;
        penable = 1'b1;
        acc = 1;
        while (!pready && acc < BOUND) begin
            @(posedge pclock); #1;
            acc++;
        end
        check_eq("t8.pre.prdata", prdata, 32'hA5A5_5A5A);
        #1;
        preset = 1'b0;
        #1;
        check_eq("t8.rst.pready", {31'h0, pready}, 32'h0);
        check_eq("t8.rst.prdata", prdata, 32'h0);
        check_eq("t8.rst.pslverr", {31'h0, pslverr}, 32'h0);
        check_eq("t8.rst.ctrl_out", ctrl_out, 32'h0);
        for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
        psel = 16'h0; penable = 1'b0;
        @(negedge pclock);
        preset = 1'b1;
        @(posedge pclock); #1;
        do_and_check("t8.after", 1'b0, BASE + 32'h8, 32'h0);

        rd  = 32'h0;
        err = 1'b0;
        if (err) rd = 32'h1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
